// File: rtl/vga_grid_renderer_if.sv
// Bus between vga_grid_renderer and its surroundings: block RAM read port,
// palette write port and the timed video outputs.
interface vga_grid_renderer_if #(
   parameter int ADDR_W = 9,
   parameter int BITS   = 2
);
   logic [ADDR_W-1:0] BlockAddr;
   logic [BITS-1:0]   BlockData;
   logic              PalWe;
   logic [BITS-1:0]   PalIdx;
   logic [7:0]        PalColor;
   logic [7:0]        RGB;
   logic              HSync;
   logic              VSync;
   logic              DataEnable;
   logic              FrameStart;

   modport master (
      output BlockAddr, RGB, HSync, VSync, DataEnable, FrameStart,
      input  BlockData, PalWe, PalIdx, PalColor
   );

   modport slave (
      input  BlockAddr, RGB, HSync, VSync, DataEnable, FrameStart,
      output BlockData, PalWe, PalIdx, PalColor
   );
endinterface

// File: rtl/vga_grid_renderer.sv
// VGA timing generator that paints a block-tiled image from external RAM
// through a writable palette. Define VGA_GRID_LINES_EN to overlay block grid lines.
module vga_grid_renderer #(
   parameter int         H_PIXELS = 640,
   parameter int         H_FP     = 16,
   parameter int         H_SYNC   = 96,
   parameter int         H_BP     = 48,
   parameter int         V_PIXELS = 480,
   parameter int         V_FP     = 10,
   parameter int         V_SYNC   = 2,
   parameter int         V_BP     = 33,
   parameter logic [1:0] SYNC_POL = 2'b00,
   parameter int         BLOCK_W  = 32,
   parameter int         BLOCK_H  = 32,
   parameter int         BITS     = 2
) (
   input  logic Clock,
   input  logic ResetN,
   vga_grid_renderer_if.master bus
);
   localparam int H_PERIOD = H_PIXELS + H_FP + H_SYNC + H_BP;
   localparam int V_PERIOD = V_PIXELS + V_FP + V_SYNC + V_BP;
   localparam int GRID_W   = H_PIXELS / BLOCK_W;
   localparam int GRID_H   = V_PIXELS / BLOCK_H;
   localparam int ADDR_W   = (GRID_W * GRID_H > 1) ? $clog2(GRID_W * GRID_H) : 1;
   localparam int HCW      = $clog2(H_PERIOD);
   localparam int VCW      = $clog2(V_PERIOD);
   localparam int BW_SH    = $clog2(BLOCK_W);
   localparam int BH_SH    = $clog2(BLOCK_H);
   localparam int PAL_N    = 1 << BITS;

   localparam logic [HCW-1:0]    H_LAST   = HCW'(H_PERIOD - 1);
   localparam logic [HCW-1:0]    H_ACT    = HCW'(H_PIXELS);
   localparam logic [HCW-1:0]    HS_ON    = HCW'(H_PIXELS + H_FP);
   localparam logic [HCW-1:0]    HS_OFF   = HCW'(H_PIXELS + H_FP + H_SYNC);
   localparam logic [VCW-1:0]    V_LAST   = VCW'(V_PERIOD - 1);
   localparam logic [VCW-1:0]    V_ACT    = VCW'(V_PIXELS);
   localparam logic [VCW-1:0]    VS_ON    = VCW'(V_PIXELS + V_FP);
   localparam logic [VCW-1:0]    VS_OFF   = VCW'(V_PIXELS + V_FP + V_SYNC);
   localparam logic [ADDR_W-1:0] GRID_W_A = ADDR_W'(GRID_W);

   function automatic logic [7:0] pal_rst(input int idx);
      case (idx)
         0:       return 8'h00;
         1:       return 8'h1C;
         2:       return 8'hE0;
         default: return 8'hFF;
      endcase
   endfunction

   logic [HCW-1:0]    h_cnt_q, h_cnt_d;
   logic [VCW-1:0]    v_cnt_q, v_cnt_d;
   logic              active, hs_raw, vs_raw, fs_raw;
   logic [ADDR_W-1:0] row_a, col_a;
   logic              act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d, fs1_q, fs1_d;
   logic [7:0]        rgb2_q, rgb2_d;
   logic              de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d, fs2_q, fs2_d;
   logic [7:0]        pal_q [PAL_N];
   logic [7:0]        pal_d [PAL_N];
   logic [BITS-1:0]   code;
`ifdef VGA_GRID_LINES_EN
   localparam logic [HCW-1:0]  BW_MASK  = HCW'(BLOCK_W - 1);
   localparam logic [VCW-1:0]  BH_MASK  = VCW'(BLOCK_H - 1);
   localparam logic [BITS-1:0] CODE_MAX = '1;
   logic grid1_q, grid1_d;
`endif

   always_comb begin
      h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end

      active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      hs_raw = (h_cnt_q >= HS_ON) && (h_cnt_q < HS_OFF);
      vs_raw = (v_cnt_q >= VS_ON) && (v_cnt_q < VS_OFF);
      fs_raw = (h_cnt_q == '0) && (v_cnt_q == '0);

      // Block sizes are powers of two, so the divides reduce to shifts.
      row_a = ADDR_W'(v_cnt_q >> BH_SH);
      col_a = ADDR_W'(h_cnt_q >> BW_SH);
      bus.BlockAddr = active ? (row_a * GRID_W_A + col_a) : '0;

      // Stage 1 travels alongside the RAM read of BlockAddr.
      act1_d = active;
      hs1_d  = hs_raw;
      vs1_d  = vs_raw;
      fs1_d  = fs_raw;
`ifdef VGA_GRID_LINES_EN
      grid1_d = ((h_cnt_q & BW_MASK) == '0) || ((v_cnt_q & BH_MASK) == '0);
      code    = grid1_q ? CODE_MAX : bus.BlockData;
`else
      code    = bus.BlockData;
`endif

      // Lookup reads pal_q, so a write on this same edge is not yet visible.
      rgb2_d = act1_q ? pal_q[code] : 8'h00;
      de2_d  = act1_q;
      hs2_d  = hs1_q ? SYNC_POL[1] : ~SYNC_POL[1];
      vs2_d  = vs1_q ? SYNC_POL[0] : ~SYNC_POL[0];
      fs2_d  = fs1_q & act1_q;

      pal_d = pal_q;
      if (bus.PalWe) begin
         pal_d[bus.PalIdx] = bus.PalColor;
      end
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         act1_q  <= 1'b0;
         hs1_q   <= 1'b0;
         vs1_q   <= 1'b0;
         fs1_q   <= 1'b0;
         rgb2_q  <= 8'h00;
         de2_q   <= 1'b0;
         hs2_q   <= ~SYNC_POL[1];
         vs2_q   <= ~SYNC_POL[0];
         fs2_q   <= 1'b0;
         for (int i = 0; i < PAL_N; i++) begin
            pal_q[i] <= pal_rst(i);
         end
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         act1_q  <= act1_d;
         hs1_q   <= hs1_d;
         vs1_q   <= vs1_d;
         fs1_q   <= fs1_d;
         rgb2_q  <= rgb2_d;
         de2_q   <= de2_d;
         hs2_q   <= hs2_d;
         vs2_q   <= vs2_d;
         fs2_q   <= fs2_d;
         pal_q   <= pal_d;
      end
   end

`ifdef VGA_GRID_LINES_EN
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) grid1_q <= 1'b0;
      else         grid1_q <= grid1_d;
   end
`endif

   assign bus.RGB        = rgb2_q;
   assign bus.DataEnable = de2_q;
   assign bus.HSync      = hs2_q;
   assign bus.VSync      = vs2_q;
   assign bus.FrameStart = fs2_q;
endmodule

// File: tb/tb_vga_grid_renderer.sv
// Self-checking bench for vga_grid_renderer on a reduced 80x39 raster with
// mixed sync polarity; a frame-position model predicts every output each cycle.
module tb_vga_grid_renderer;
   localparam int         HPIX = 64, HFP = 4, HSW = 8, HBP = 4;
   localparam int         VPIX = 32, VFP = 2, VSW = 2, VBP = 3;
   localparam int         HP = HPIX + HFP + HSW + HBP;
   localparam int         VP = VPIX + VFP + VSW + VBP;
   localparam int         FRAME = HP * VP;
   localparam int         BW = 16, BH = 8;
   localparam int         GW = HPIX / BW, GH = VPIX / BH;
   localparam int         NBLK = GW * GH;
   localparam int         AW = 4;
   localparam int         BITS = 2;
   localparam int         PN = 1 << BITS;
   localparam logic [1:0] POL = 2'b10;

   logic Clock  = 1'b0;
   logic ResetN = 1'b1;
   always #5 Clock = ~Clock;

   vga_grid_renderer_if #(.ADDR_W(AW), .BITS(BITS)) bus ();

   vga_grid_renderer #(
      .H_PIXELS(HPIX), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_PIXELS(VPIX), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .SYNC_POL(POL), .BLOCK_W(BW), .BLOCK_H(BH), .BITS(BITS)
   ) dut (
      .Clock (Clock),
      .ResetN(ResetN),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;
   int n = 0;
   logic [7:0]      pal [PN];
   logic [7:0]      pal_prev [PN];
   logic [BITS-1:0] mem [NBLK];
   logic            chk_en = 1'b0;
   logic            stat_en = 1'b1;

   int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, e0_cnt = 0, c1_cnt = 0, ff_cnt = 0;
   int fs_first = -1, fs_second = -1, hs_rise0 = -1, hs_rise1 = -1, vs_rise0 = -1;
   logic hs_prev = 1'b0, vs_prev = 1'b0;

   function automatic logic [7:0] pal_init(input int idx);
      case (idx)
         0:       return 8'h00;
         1:       return 8'h1C;
         2:       return 8'hE0;
         default: return 8'hFF;
      endcase
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, n);
      end
   endtask

   task automatic wait_n(input int target);
      for (int i = 0; i < 20000 && n < target; i++) @(negedge Clock);
      if (n != target) begin
         checks++;
         failures++;
         $display("FAIL wait_edge: reached %0d expected %0d", n, target);
      end
   endtask

   task automatic wait_fs(input string nm);
      for (int i = 0; i < 10 && bus.FrameStart !== 1'b1; i++) @(negedge Clock);
      check(nm, n, 2);
   endtask

   // External synchronous block RAM.
   always @(posedge Clock) bus.BlockData <= mem[bus.BlockAddr];

   // n = rising edges since reset release; pal_prev is the palette before the latest edge.
   always @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         n <= 0;
         for (int i = 0; i < PN; i++) begin
            pal[i]      <= pal_init(i);
            pal_prev[i] <= pal_init(i);
         end
      end else begin
         n        <= n + 1;
         pal_prev <= pal;
         if (bus.PalWe) pal[bus.PalIdx] <= bus.PalColor;
      end
   end

   int q, qh, qv, p, h, v, e_addr;
   logic [7:0] e_rgb;
   logic e_de, e_hs, e_vs, e_fs, hs_now, vs_now;

   always @(negedge Clock) begin
      if (chk_en) begin
         q  = n % FRAME;
         qh = q % HP;
         qv = q / HP;
         e_addr = (qh < HPIX && qv < VPIX) ? (qv / BH) * GW + qh / BW : 0;
         if (n < 2) begin
            e_rgb = 8'h00; e_de = 1'b0; e_fs = 1'b0;
            e_hs = ~POL[1]; e_vs = ~POL[0];
         end else begin
            p = (n - 2) % FRAME;
            h = p % HP;
            v = p / HP;
            e_de = (h < HPIX) && (v < VPIX);
            e_hs = (h >= HPIX + HFP && h < HPIX + HFP + HSW) ? POL[1] : ~POL[1];
            e_vs = (v >= VPIX + VFP && v < VPIX + VFP + VSW) ? POL[0] : ~POL[0];
            e_fs = (p == 0);
            e_rgb = 8'h00;
            if (e_de) begin
               e_rgb = pal_prev[mem[(v / BH) * GW + h / BW]];
`ifdef VGA_GRID_LINES_EN
               if (h % BW == 0 || v % BH == 0) e_rgb = pal_prev[PN-1];
`endif
            end
         end
         check("block_addr", int'(bus.BlockAddr), e_addr);
         check("rgb", int'(bus.RGB), int'(e_rgb));
         check("data_enable", int'(bus.DataEnable), int'(e_de));
         check("hsync", int'(bus.HSync), int'(e_hs));
         check("vsync", int'(bus.VSync), int'(e_vs));
         check("frame_start", int'(bus.FrameStart), int'(e_fs));

         hs_now = (bus.HSync === POL[1]);
         vs_now = (bus.VSync === POL[0]);
         if (stat_en && n >= 2 && n < 2 + FRAME) begin
            if (bus.DataEnable === 1'b1) de_cnt++;
            if (hs_now) hs_cnt++;
            if (vs_now) vs_cnt++;
            if (bus.RGB === 8'hE0) e0_cnt++;
            if (bus.RGB === 8'h1C) c1_cnt++;
            if (bus.RGB === 8'hFF) ff_cnt++;
            if (hs_now && !hs_prev) begin
               if (hs_rise0 < 0) hs_rise0 = n;
               else if (hs_rise1 < 0) hs_rise1 = n;
            end
            if (vs_now && !vs_prev && vs_rise0 < 0) vs_rise0 = n;
         end
         if (stat_en && bus.FrameStart === 1'b1) begin
            if (fs_first < 0) fs_first = n;
            else if (fs_second < 0) fs_second = n;
         end
         hs_prev = hs_now;
         vs_prev = vs_now;
      end
   end

   int t;
   initial begin
      bus.PalWe = 1'b0;
      bus.PalIdx = '0;
      bus.PalColor = 8'h00;
      for (int i = 0; i < NBLK; i++) mem[i] = '0;
      mem[5] = 2'd2;   // block column 1, row 1
      mem[6] = 2'd1;   // block column 2, row 1

      #2 ResetN = 1'b0;
      chk_en = 1'b1;
      #1;
      check("rst_rgb", int'(bus.RGB), 0);
      check("rst_de", int'(bus.DataEnable), 0);
      check("rst_fs", int'(bus.FrameStart), 0);
      check("rst_hsync_idle", int'(bus.HSync), 0);
      check("rst_vsync_idle", int'(bus.VSync), 1);
      repeat (3) @(negedge Clock);
      #1 ResetN = 1'b1;

      wait_fs("first_fs_edge");
      wait_n(3 + FRAME);
      stat_en = 1'b0;
      check("fs_period", fs_second - fs_first, 3120);
      check("de_per_frame", de_cnt, 2048);
      check("hs_active_per_frame", hs_cnt, 312);
      check("vs_active_per_frame", vs_cnt, 160);
      check("hs_first_edge", hs_rise0, 70);
      check("hs_period", hs_rise1 - hs_rise0, 80);
      check("vs_first_edge", vs_rise0, 2722);
`ifdef VGA_GRID_LINES_EN
      check("e0_pixels", e0_cnt, 105);
      check("1c_pixels", c1_cnt, 105);
      check("ff_pixels", ff_cnt, 368);
`else
      check("e0_pixels", e0_cnt, 128);
      check("1c_pixels", c1_cnt, 128);
      check("ff_pixels", ff_cnt, 0);
`endif

      // Palette write while the output shows pixel (40,10) of frame 2.
      t = 2 + FRAME + 10 * HP + 40;
      wait_n(t);
      #1;
      bus.PalWe = 1'b1;
      bus.PalIdx = 2'd1;
      bus.PalColor = 8'h03;
      @(negedge Clock);
      check("pal_same_edge_old", int'(bus.RGB), 8'h1C);
      #1 bus.PalWe = 1'b0;
      @(negedge Clock);
      check("pal_next_new", int'(bus.RGB), 8'h03);

      // Reset mid-frame while the output shows pixel (20,12), inside block 5.
      t = 2 + 2 * FRAME + 12 * HP + 20;
      wait_n(t);
      check("pre_rst_rgb", int'(bus.RGB), 8'hE0);
      check("pre_rst_de", int'(bus.DataEnable), 1);
      #1 ResetN = 1'b0;
      #1;
      check("mid_rst_rgb", int'(bus.RGB), 0);
      check("mid_rst_de", int'(bus.DataEnable), 0);
      check("mid_rst_hsync", int'(bus.HSync), 0);
      check("mid_rst_vsync", int'(bus.VSync), 1);
      repeat (3) @(negedge Clock);
      #1 ResetN = 1'b1;
      wait_fs("fs_after_mid_rst");
      wait_n(2 + 10 * HP + 40);
      check("pal_restored", int'(bus.RGB), 8'h1C);
      wait_n(FRAME / 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vga_grid_renderer.md
VGA_GRID_RENDERER -- requirements
Module: vga_grid_renderer

Interface
REQ-001 SHALL have parameter H_PIXELS, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in clocks.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in clocks.
REQ-005 SHALL have parameter V_PIXELS, default 480, active lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter SYNC_POL, default 2'b00, bit1=HSync active level, bit0=VSync active level.
REQ-010 SHALL have parameter BLOCK_W, default 32, block width in pixels, power of two; GRID_W=H_PIXELS/BLOCK_W.
REQ-011 SHALL have parameter BLOCK_H, default 32, block height in lines, power of two; GRID_H=V_PIXELS/BLOCK_H.
REQ-012 SHALL have parameter BITS, default 2, block code width, 1..4; palette has 2^BITS entries.
REQ-013 SHALL have port Clock  input  1  pixel clock, all logic on rising edge; one clock only.
REQ-014 SHALL have port ResetN  input  1  asynchronous, active-low reset.
REQ-015 SHALL have port BlockAddr  output  clog2(GRID_W*GRID_H)  block index = y*GRID_W+x to external synchronous RAM.
REQ-016 SHALL have port BlockData  input  BITS  block code, valid exactly one clock after BlockAddr.
REQ-017 SHALL have port PalWe  input  1  palette write strobe.
REQ-018 SHALL have port PalIdx  input  BITS  palette entry to write.
REQ-019 SHALL have port PalColor  input  8  RRRGGGBB colour to write.
REQ-020 SHALL have port RGB  output  8  pixel colour, RRRGGGBB.
REQ-021 SHALL have ports HSync, VSync  output  1 each  sync pulses, polarity per SYNC_POL.
REQ-022 SHALL have port DataEnable  output  1  high while RGB is an active pixel.
REQ-023 SHALL have port FrameStart  output  1  one-clock pulse aligned with pixel (0,0) on RGB.

Function
REQ-024 hCnt SHALL count 0..H_PERIOD-1 (H_PERIOD=sum of H params), wrapping to 0.
REQ-025 vCnt SHALL increment only when hCnt wraps, counting 0..V_PERIOD-1, wrapping to 0.
REQ-026 Active region SHALL be hCnt<H_PIXELS and vCnt<V_PIXELS.
REQ-027 Sync SHALL be asserted for hCnt in [H_PIXELS+H_FP, H_PIXELS+H_FP+H_SYNC) and likewise vertically; exactly H_SYNC clocks / V_SYNC lines.
REQ-028 BlockAddr SHALL be (vCnt/BLOCK_H)*GRID_W+(hCnt/BLOCK_W) combinationally from the counters, computed with shifts; outside active region it SHALL hold 0.
REQ-029 Pipeline SHALL be 2 stages: stage1 registers active/sync flags alongside the RAM read; stage2 registers palette lookup into RGB.
REQ-030 HSync, VSync, DataEnable, FrameStart SHALL be delayed 2 clocks so all outputs align with RGB.
REQ-031 RGB SHALL be 8'h00 whenever DataEnable is low.
REQ-032 Palette write SHALL take effect on the next clock edge; a lookup on the same clock as a write SHALL return the old value.
REQ-033 BlockData codes SHALL index palette directly; no code is illegal.

Reset
REQ-034 ResetN low SHALL immediately clear hCnt, vCnt, pipeline flags; RGB=0, DataEnable=0, FrameStart=0, HSync=~SYNC_POL[1], VSync=~SYNC_POL[0].
REQ-035 Reset SHALL load palette: entry0=8'h00, entry1=8'h1C, entry2=8'hE0, all others 8'hFF.
REQ-036 After ResetN rises, first FrameStart SHALL appear 2 clocks after the first rising edge; reset mid-frame restarts at (0,0).

Configuration
REQ-037 With VGA_GRID_LINES_EN defined, active pixels with hCnt%BLOCK_W==0 or vCnt%BLOCK_H==0 SHALL output palette entry (2^BITS)-1 regardless of BlockData.
REQ-038 Without VGA_GRID_LINES_EN, every active pixel SHALL use the palette colour of its BlockData.

Verification
REQ-039 Defaults, reset, run 2 frames -> HSync period 800 clocks, low 96; VSync period 420000 clocks, low 2 lines; FrameStart every 420000 clocks.
REQ-040 RAM model returns code 2 at address 21, 0 elsewhere -> RGB=8'hE0 for pixels x 32..63, y 32..63 only; 8'h00 elsewhere.
REQ-041 PalWe, PalIdx=1, PalColor=8'h03 mid-line -> code-1 pixels switch to 8'h03 from the next pixel's stage-2 output onward.
REQ-042 SYNC_POL=2'b11 -> sync idle low, pulses high; widths unchanged.
REQ-043 ResetN pulsed low at hCnt=300,vCnt=200 -> outputs reset immediately; next FrameStart 2 clocks after release.
REQ-044 VGA_GRID_LINES_EN defined, all codes 0 -> RGB=8'hFF on columns 0,32,... and lines 0,32,...; 8'h00 elsewhere.
